// File: rtl/execute_muldiv.sv
// execute_muldiv: multi-cycle multiply/divide unit owning the HI/LO registers.
// MULT/MULTU finish MUL_CYCLES edges after accept; DIV/DIVU run a restoring
// radix-2 divider on magnitudes (WIDTH steps) plus one sign-fix cycle.
module execute_muldiv #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + MUL_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DFIX} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  a_q, b_q;       // original operands (div-by-zero, signs)
  logic              sgn_q;          // signed flavour of the op
  logic [WIDTH-1:0]  rem_q, quo_q, dvs_q;
  logic [WIDTH-1:0]  hi_q, lo_q;
  logic              done_q;

  logic              accept;
  logic              op_signed, op_is_mul;
  logic [WIDTH-1:0]  a_mag, b_mag;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  logic [WIDTH:0]    shl, diff;
  logic [WIDTH-1:0]  rem_n, quo_n;
  logic              q_neg, r_neg;

  assign accept    = in_valid && in_ready;
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign op_is_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign a_mag     = (op_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign b_mag     = (op_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

  // Product from latched operands; truncated 2W-bit multiply of the
  // sign/zero-extended operands gives the exact signed or unsigned result.
  assign ext_a = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
  assign ext_b = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
  assign prod  = ext_a * ext_b;

  // One restoring step: shift next dividend bit in, subtract if it fits.
  assign shl   = {rem_q, quo_q[WIDTH-1]};
  assign diff  = shl - {1'b0, dvs_q};
  assign rem_n = diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_n = {quo_q[WIDTH-2:0], ~diff[WIDTH]};

  assign q_neg = sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
  assign r_neg = sgn_q && a_q[WIDTH-1];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; flush always returns to IDLE
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          if (op_is_mul)                          state_d = S_MUL;
          else if (op == OP_DIV || op == OP_DIVU) state_d = S_DIV;
        end
        S_MUL:  if (cnt_q == CW'(MUL_CYCLES)) state_d = S_IDLE;
        S_DIV:  if (cnt_q == CW'(WIDTH - 1))  state_d = S_DFIX;
        S_DFIX: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Handshake/status outputs
  always_comb begin
    in_ready = (state_q == S_IDLE) && !flush;
    busy     = (state_q != S_IDLE);
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Datapath: operand capture, iteration, HI/LO commit and done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sgn_q  <= 1'b0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (accept) begin
          a_q   <= a;
          b_q   <= b;
          sgn_q <= op_signed;
          cnt_q <= op_is_mul ? CW'(1) : '0;
          rem_q <= '0;
          quo_q <= a_mag;
          dvs_q <= b_mag;
          if (op == OP_MTHI) begin
            hi_q   <= a;
            done_q <= 1'b1;
          end
          if (op == OP_MTLO) begin
            lo_q   <= a;
            done_q <= 1'b1;
          end
        end
        S_MUL: if (!flush) begin
          if (cnt_q == CW'(MUL_CYCLES)) begin
            {hi_q, lo_q} <= prod;
            done_q       <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DIV: if (!flush) begin
          rem_q <= rem_n;
          quo_q <= quo_n;
          cnt_q <= cnt_q + CW'(1);
        end
        S_DFIX: if (!flush) begin
          done_q <= 1'b1;
          if (b_q == '0) begin
            lo_q <= '1;
            hi_q <= a_q;
          end else begin
            lo_q <= q_neg ? (~quo_q + 1'b1) : quo_q;
            hi_q <= r_neg ? (~rem_q + 1'b1) : rem_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
